// File: rtl/bnn_pkg.sv
// Shared constants for the binary conv / FC datapath: widths, layer geometry,
// layer codes, ROM address bases and the line-buffer tap lookup.
package bnn_pkg;

  localparam int WL       = 1;
  localparam int CH       = 48;
  localparam int WE       = 9;
  localparam int TH       = 11;
  localparam int OL       = 108;
  localparam int OL_conv3 = 54;
  localparam int OL_fc    = 13;
  localparam int CO       = 6;
  localparam int CO_fc    = 7;
  localparam int TH_fc    = 13;

  // Input geometry per conv layer (width / height in pixels)
  localparam int W_C2 = 14;
  localparam int H_C2 = 11;
  localparam int W_C3 = 11;
  localparam int H_C3 = 8;

  localparam int MAP_W  = W_C2 * H_C2;   // 154-bit padded output map
  localparam int LB_LEN = 2 * W_C2 + 2;  // stored pixels; the newest comes straight from the input

  typedef enum logic [4:0] {
    LAYER_CONV2 = 5'd7,
    LAYER_CONV3 = 5'd11,
    LAYER_FC    = 5'd15
  } layer_e;

  localparam int WROM_BASE_CONV2 = 0;
  localparam int WROM_BASE_CONV3 = 48;
  localparam int WROM_BASE_FC    = 96;  // plus class * 48
  localparam int TROM_BASE_CONV2 = 0;
  localparam int TROM_BASE_CONV3 = 48;

  // Line-buffer slot holding kernel tap t (ky*3+kx); slot 0 is the previous pixel.
  // Tap 8 is the live input pixel and has no slot.
  function automatic logic [4:0] tap_idx(input logic is_c2, input int t);
    int w;
    w = is_c2 ? W_C2 : W_C3;
    return 5'((2 - t / 3) * w + (2 - t % 3) - 1);
  endfunction

endpackage

// File: rtl/bnn_popcount_432.sv
// Combinational population count of a 432-bit vector: 48-bit group counts
// summed into a 9-bit total.
module bnn_popcount_432
  import bnn_pkg::*;
(
  input  logic [WE*CH-1:0] bits,
  output logic [8:0]       count
);

  logic [5:0] grp [WE];

  always_comb begin
    for (int g = 0; g < WE; g++) begin
      grp[g] = '0;
      for (int b = 0; b < CH; b++) begin
        grp[g] = grp[g] + 6'(bits[g*CH+b]);
      end
    end
    count = '0;
    for (int g = 0; g < WE; g++) begin
      count = count + 9'(grp[g]);
    end
  end

endmodule

// File: rtl/bnn.sv
// One output channel of a 3x3 binary convolution (conv2/conv3) over a raster
// pixel stream, or one FC partial dot product, sharing a single popcount.
module bnn
  import bnn_pkg::*;
(
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic [4:0]              STATE,
  input  logic [3:0]              iSTART,
  input  logic [WL*CH-1:0]        iDATA,
  input  logic [WE*CH-1:0]        iWEIGHT,
  input  logic [WL*CH-1:0]        iWEIGHT_FC,
  input  logic signed [TH-1:0]    iTH,
  input  logic                    iEN,
  output logic [MAP_W-1:0]        oDATA,
  output logic signed [OL_fc-1:0] oDATA_fc_SPI
);

  // No handshake: iEN qualifies iDATA for exactly one cycle, gaps are free,
  // and any iSTART bit in the same cycle takes priority and drops the pixel.

  logic              is_c2, is_conv, is_fc, start_any, conv_clear;
  logic              conv_take, fc_take, out_bit;
  logic [7:0]        k, npix, w8, wr_idx;
  logic [3:0]        row, col, w_last;
  logic [CH-1:0]     lb [LB_LEN];
  logic [WE*CH-1:0]  win, pc_in;
  logic [8:0]        pc;
  logic signed [11:0] s_win, th_ext;
  logic signed [OL_fc-1:0] fc_delta;

  assign is_c2      = (STATE == LAYER_CONV2);
  assign is_conv    = is_c2 || (STATE == LAYER_CONV3);
  assign is_fc      = (STATE == LAYER_FC);
  assign start_any  = |iSTART;
  assign conv_clear = iSTART[1] | iSTART[2];

  assign npix   = is_c2 ? 8'(W_C2 * H_C2) : 8'(W_C3 * H_C3);
  assign w8     = is_c2 ? 8'(W_C2) : 8'(W_C3);
  assign w_last = is_c2 ? 4'(W_C2 - 1) : 4'(W_C3 - 1);

  assign conv_take = iEN && is_conv && !start_any && (k != npix);
  assign fc_take   = iEN && is_fc && !start_any;

  // Window ending at the live pixel: tap 8 is iDATA, the rest come from the buffer
  always_comb begin
    win = '0;
    for (int t = 0; t < WE; t++) begin
      if (t == WE - 1) win[t*CH +: CH] = iDATA;
      else             win[t*CH +: CH] = lb[tap_idx(is_c2, t)];
    end
  end

  assign pc_in = is_fc ? {{(WE*CH-CH){1'b0}}, ~(iDATA ^ iWEIGHT_FC)} : ~(win ^ iWEIGHT);

  bnn_popcount_432 u_popcount (
    .bits  (pc_in),
    .count (pc)
  );

  assign s_win    = $signed({2'b00, pc, 1'b0}) - 12'sd432;
  assign th_ext   = {{(12-TH){iTH[TH-1]}}, iTH};
  assign out_bit  = (s_win >= th_ext);
  assign fc_delta = $signed({3'b000, pc, 1'b0}) - 13'sd48;

  // Output (row-2, col-2) lands at padded position (row-1)*W + (col-1)
  assign wr_idx = ({4'b0, row} - 8'd1) * w8 + {4'b0, col} - 8'd1;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      k            <= '0;
      row          <= '0;
      col          <= '0;
      oDATA        <= '0;
      oDATA_fc_SPI <= '0;
      for (int i = 0; i < LB_LEN; i++) lb[i] <= '0;
    end else begin
      if (conv_clear) begin
        k     <= '0;
        row   <= '0;
        col   <= '0;
        oDATA <= '0;
        for (int i = 0; i < LB_LEN; i++) lb[i] <= '0;
      end else if (conv_take) begin
        lb[0] <= iDATA;
        for (int i = 1; i < LB_LEN; i++) lb[i] <= lb[i-1];
        k <= k + 8'd1;
        if (col == w_last) begin
          col <= '0;
          row <= row + 4'd1;
        end else begin
          col <= col + 4'd1;
        end
        if (row >= 4'd2 && col >= 4'd2) oDATA[wr_idx] <= out_bit;
      end

      if (iSTART[0])    oDATA_fc_SPI <= '0;
      else if (fc_take) oDATA_fc_SPI <= oDATA_fc_SPI + fc_delta;
    end
  end

endmodule

// File: tb/tb_bnn.sv
// Self-checking bench for bnn: randomized conv/FC streams against a
// window-by-window reference model of the padded output map and the FC sum.
module tb_bnn;

  logic                iCLK;
  logic                iRST;
  logic [4:0]          STATE;
  logic [3:0]          iSTART;
  logic [47:0]         iDATA;
  logic [431:0]        iWEIGHT;
  logic [47:0]         iWEIGHT_FC;
  logic signed [10:0]  iTH;
  logic                iEN;
  logic [153:0]        oDATA;
  logic signed [12:0]  oDATA_fc_SPI;

  bnn dut (
    .iCLK         (iCLK),
    .iRST         (iRST),
    .STATE        (STATE),
    .iSTART       (iSTART),
    .iDATA        (iDATA),
    .iWEIGHT      (iWEIGHT),
    .iWEIGHT_FC   (iWEIGHT_FC),
    .iTH          (iTH),
    .iEN          (iEN),
    .oDATA        (oDATA),
    .oDATA_fc_SPI (oDATA_fc_SPI)
  );

  // clock / reset
  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // scoreboard state
  int                 n_cmp = 0;
  int                 n_bad = 0;
  logic [153:0]       exp_q[$];

  // reference model state
  logic [47:0]        img [154];
  int                 n_acc = 0;
  bit                 cur_c2 = 1'b1;
  logic signed [10:0] cur_th = '0;
  logic [431:0]       cur_wt = '0;
  logic [12:0]        fc_m = '0;

  task automatic check(input string tag, input logic [153:0] got, input logic [153:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int npix_of(input bit c2);
    return c2 ? 154 : 88;
  endfunction

  // Expected padded map from the pixels received so far: a window contributes
  // only once its bottom-right pixel has arrived.
  function automatic logic [153:0] model_map();
    logic [153:0] m;
    int w, h, s;
    w = cur_c2 ? 14 : 11;
    h = cur_c2 ? 11 : 8;
    m = '0;
    for (int r = 0; r <= h - 3; r++) begin
      for (int c = 0; c <= w - 3; c++) begin
        if ((r + 2) * w + c + 2 < n_acc) begin
          s = 0;
          for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++)
              s += $countones(~(img[(r+ky)*w + c + kx] ^ cur_wt[(ky*3+kx)*48 +: 48]));
          s = 2 * s - 432;
          if (s >= int'(cur_th)) m[(r+1)*w + c + 1] = 1'b1;
        end
      end
    end
    return m;
  endfunction

  // driver: one conv-side cycle, then compare the map against the model
  task automatic pix_step(input logic [47:0] d, input bit en, input logic [3:0] st);
    iDATA   = d;
    iEN     = en;
    iSTART  = st;
    iTH     = cur_th;
    iWEIGHT = cur_wt;
    @(posedge iCLK);
    #1;
    iEN    = 1'b0;
    iSTART = 4'b0000;
    if (st[1] || st[2]) n_acc = 0;
    else if (st == 4'b0000 && en && n_acc < npix_of(cur_c2)) begin
      img[n_acc] = d;
      n_acc++;
    end
    exp_q.push_back(model_map());
    check("odata", oDATA, exp_q.pop_front());
  endtask

  // driver: one FC cycle, then compare the accumulator
  task automatic fc_step(input logic [47:0] d, input logic [47:0] wt, input bit en, input logic [3:0] st);
    int cnt;
    iDATA      = d;
    iWEIGHT_FC = wt;
    iEN        = en;
    iSTART     = st;
    @(posedge iCLK);
    #1;
    iEN    = 1'b0;
    iSTART = 4'b0000;
    cnt = $countones(~(d ^ wt));
    if (st[0]) fc_m = '0;
    else if (st == 4'b0000 && en) fc_m = fc_m + 13'(2 * cnt - 48);
    exp_q.push_back({141'b0, fc_m});
    check("fc_acc", {141'b0, oDATA_fc_SPI}, exp_q.pop_front());
  endtask

  function automatic logic [47:0] rand48();
    return {16'($urandom), $urandom};
  endfunction

  function automatic logic [47:0] pix_of(input int kind, input int i);
    int w;
    w = cur_c2 ? 14 : 11;
    case (kind)
      0:       return '1;
      1:       return '0;
      2:       return (((i / w) + (i % w)) % 2 == 1) ? 48'hffff_ffff_ffff : 48'h0;
      default: return rand48();
    endcase
  endfunction

  // Stream n pixels of the given kind, inserting random idle cycles when gap_max > 0
  task automatic stream(input int kind, input int n, input int gap_max);
    for (int i = 0; i < n; i++) begin
      if (gap_max > 0) begin
        int g;
        g = $urandom_range(0, gap_max);
        for (int j = 0; j < g; j++) pix_step(rand48(), 1'b0, 4'b0000);
      end
      pix_step(pix_of(kind, n_acc), 1'b1, 4'b0000);
    end
  endtask

  task automatic conv_pass(input bit c2, input int kind, input int gap_max);
    cur_c2 = c2;
    STATE  = c2 ? 5'd7 : 5'd11;
    pix_step('0, 1'b0, c2 ? 4'b0010 : 4'b0100);
    stream(kind, npix_of(c2), gap_max);
  endtask

  initial begin
    int tmp;
    iRST       = 1'b0;
    STATE      = 5'd0;
    iSTART     = 4'b0000;
    iDATA      = '0;
    iWEIGHT    = '0;
    iWEIGHT_FC = '0;
    iTH        = '0;
    iEN        = 1'b0;
    repeat (3) @(posedge iCLK);
    #1;
    check("rst_odata", oDATA, '0);
    check("rst_fc", {141'b0, oDATA_fc_SPI}, '0);
    iRST = 1'b1;
    @(posedge iCLK);
    #1;

    // FC accumulate, partial weight, no-clear start, wrap, random
    STATE = 5'd15;
    fc_step('1, '1, 1'b0, 4'b0001);
    for (int i = 0; i < 3; i++) fc_step('1, '1, 1'b1, 4'b0000);
    check("fc_144", {141'b0, oDATA_fc_SPI}, 154'd144);
    fc_step('1, '0, 1'b1, 4'b0000);
    check("fc_96", {141'b0, oDATA_fc_SPI}, 154'd96);
    fc_step('1, '1, 1'b0, 4'b1000);
    check("fc_keep", {141'b0, oDATA_fc_SPI}, 154'd96);
    fc_step('0, '0, 1'b0, 4'b0001);
    for (int i = 0; i < 100; i++) fc_step('1, '1, 1'b1, 4'b0000);
    check("fc_wrap", {141'b0, oDATA_fc_SPI}, {141'b0, 13'(4800)});
    for (int i = 0; i < 40; i++) fc_step(rand48(), rand48(), 1'($urandom_range(0, 1)), 4'b0000);

    // conv2 all-match at the threshold edge
    cur_wt = '1;
    cur_th = 11'sd432;
    conv_pass(1'b1, 0, 0);
    check("c2_ones", 154'($countones(oDATA)), 154'd108);
    cur_th = 11'sd433;
    conv_pass(1'b1, 0, 0);
    check("c2_zero", oDATA, '0);

    // conv3 all-mismatch at the negative threshold edge
    cur_th = -11'sd432;
    conv_pass(1'b0, 1, 0);
    check("c3_ones", 154'($countones(oDATA)), 154'd54);
    check("c3_upper", 154'(oDATA[153:88]), '0);
    cur_th = -11'sd431;
    conv_pass(1'b0, 1, 0);
    check("c3_zero", oDATA, '0);

    // gapped checkerboard conv2, random weights; extra pixels after completion
    for (int i = 0; i < 14; i++) cur_wt[i*32 +: 32] = $urandom;
    cur_wt[431:448-32] = 16'($urandom);
    tmp = int'($urandom_range(0, 60)) - 30;
    cur_th = 11'(tmp);
    conv_pass(1'b1, 2, 3);
    for (int i = 0; i < 5; i++) pix_step(rand48(), 1'b1, 4'b0000);

    // random conv3 with gaps
    for (int i = 0; i < 14; i++) cur_wt[i*32 +: 32] = $urandom;
    tmp = int'($urandom_range(0, 40)) - 20;
    cur_th = 11'(tmp);
    conv_pass(1'b0, 3, 2);

    // start with a pixel in the same cycle mid-pass: clear wins, pixel dropped
    tmp = int'($urandom_range(0, 40)) - 20;
    cur_th = 11'(tmp);
    conv_pass(1'b1, 3, 0);
    pix_step('0, 1'b0, 4'b0010);
    stream(3, 40, 1);
    pix_step(rand48(), 1'b1, 4'b0010);
    check("clr_prio", oDATA, '0);
    stream(3, 154, 1);

    // reset in the middle of a pass, then a fresh pass without a start pulse
    pix_step('0, 1'b0, 4'b0010);
    stream(3, 60, 0);
    iRST = 1'b0;
    #2;
    check("rstmid_odata", oDATA, '0);
    check("rstmid_fc", {141'b0, oDATA_fc_SPI}, '0);
    @(posedge iCLK);
    #2;
    iRST  = 1'b1;
    n_acc = 0;
    fc_m  = '0;
    stream(3, 154, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
